// File: rtl/jesd_rx_pkg.sv
// Shared types and widths for the JESD204B receive lane path.
package jesd_rx_pkg;

    localparam int RBD_W   = 5;
    localparam int OCTET_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LMFC = 3'd1,
        ST_WAIT_RBD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_ERR       = 3'd4
    } state_e;

endpackage

// File: rtl/jesd_rx_buf_ram.sv
// Simple dual-port octet store: synchronous write, registered read.
// The read register clears whenever no read is issued, so its output is zero unless valid.
module jesd_rx_buf_ram
    import jesd_rx_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [OCTET_W-1:0] wr_data,
    input  logic               rd_clr,
    input  logic [AW-1:0]      rd_addr,
    output logic [OCTET_W-1:0] rd_data
);

    logic [OCTET_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jesd_rx_lmfc_release_buffer.sv
// Per-lane elastic buffer: captures from the first SOMF octet and releases on the
// local LMFC edge plus RBD device clocks, giving deterministic link latency.
module jesd_rx_lmfc_release_buffer
    import jesd_rx_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [4:0]                 i_K,
    input  logic [RBD_W-1:0]           i_rbd,
    input  logic                       i_lmfc_clk,
    input  logic [OCTET_W-1:0]         i_data,
    input  logic                       i_valid,
    input  logic                       i_somf,
    input  logic                       i_resync,
    output logic [OCTET_W-1:0]         o_data,
    output logic                       o_valid,
    output logic                       o_released,
    output logic                       o_error,
    output logic [$clog2(DEPTH):0]     o_fill
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic [RBD_W-1:0] dly_cnt;
    logic             wr_req;
    logic             wr_en;
    logic             rd_en;
    logic             ovf;
    logic             udf;
    logic             k_unused;

    // Frames-per-multiframe is carried for the link config only; release timing ignores it.
    assign k_unused = ^i_K;

    always_comb begin
        wr_req = 1'b0;
        case (state)
            ST_IDLE:                          wr_req = i_valid & i_somf;
            ST_WAIT_LMFC, ST_WAIT_RBD, ST_RUN: wr_req = i_valid;
            default:                          wr_req = 1'b0;
        endcase
        rd_en = (state == ST_RUN) && (fill != '0);
        udf   = (state == ST_RUN) && (fill == '0);
        ovf   = wr_req && (fill == FULL) && !rd_en;
        wr_en = wr_req && !ovf;
    end

    always_ff @(posedge clk) begin
        if (i_rst || i_resync) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            dly_cnt <= '0;
            o_valid <= 1'b0;
            o_error <= 1'b0;
        end else if (ovf || udf) begin
            state   <= ST_ERR;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            o_valid <= 1'b0;
            o_error <= 1'b1;
        end else begin
            o_valid <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        state <= ST_WAIT_LMFC;
                    end
                end
                ST_WAIT_LMFC: begin
                    if (i_lmfc_clk) begin
                        if (i_rbd == '0) begin
                            state <= ST_RUN;
                        end else begin
                            dly_cnt <= i_rbd;
                            state   <= ST_WAIT_RBD;
                        end
                    end
                end
                ST_WAIT_RBD: begin
                    dly_cnt <= dly_cnt - 1'b1;
                    if (dly_cnt == RBD_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Read stage: octet addressed this cycle appears on o_data next cycle with o_valid.
    jesd_rx_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_clr  (i_rst | i_resync | ~rd_en),
        .rd_addr (rd_ptr),
        .rd_data (o_data)
    );

    assign o_released = (state == ST_RUN);
    assign o_fill     = fill;

endmodule

// File: tb/tb_jesd_rx_lmfc_release_buffer.sv
// Directed bench for the LMFC release buffer; one stream cycle per loop iteration.
module tb_jesd_rx_lmfc_release_buffer;

    logic       clk;
    logic       rst;
    logic [4:0] k;
    logic [4:0] rbd;
    logic       lmfc;
    logic [7:0] din;
    logic       vin;
    logic       somf;
    logic       resync;
    logic [7:0] dout;
    logic       vout;
    logic       released;
    logic       err;
    logic [6:0] fill;

    int n_chk;
    int n_err;

    jesd_rx_lmfc_release_buffer #(.DEPTH(64)) dut (
        .clk        (clk),
        .i_rst      (rst),
        .i_K        (k),
        .i_rbd      (rbd),
        .i_lmfc_clk (lmfc),
        .i_data     (din),
        .i_valid    (vin),
        .i_somf     (somf),
        .i_resync   (resync),
        .o_data     (dout),
        .o_valid    (vout),
        .o_released (released),
        .o_error    (err),
        .o_fill     (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s,
                         input logic l, input logic [4:0] r, input logic rs);
        vin    = v;
        din    = d;
        somf   = s;
        lmfc   = l;
        rbd    = r;
        resync = rs;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        tick();
        chk({tag, "_rst_valid"},    32'(vout),     32'd0);
        chk({tag, "_rst_data"},     32'(dout),     32'd0);
        chk({tag, "_rst_released"}, 32'(released), 32'd0);
        chk({tag, "_rst_error"},    32'(err),      32'd0);
        chk({tag, "_rst_fill"},     32'(fill),     32'd0);
        rst = 1'b0;
    endtask

    // Stream octet c on cycle c; SOMF at 16, LMFC every 32 cycles at phase lph.
    task automatic run_release(input string tag, input logic [4:0] r, input int lph,
                               input int first, input int exp_fill);
        do_reset(tag);
        for (int c = 0; c < first + 10; c++) begin
            drive(1'b1, c[7:0], c == 16, (c % 32) == lph, r, 1'b0);
            if (c == first - 2) chk({tag, "_rel_early"}, 32'(released), 32'd0);
            if (c == first - 1) begin
                chk({tag, "_rel_on"},    32'(released), 32'd1);
                chk({tag, "_pre_valid"}, 32'(vout),     32'd0);
                chk({tag, "_run_fill"},  32'(fill),     32'(exp_fill));
            end
            if (c == first + 1 - 16 + lph - lph) chk({tag, "_idle_valid"}, 32'(vout), 32'd0);
            if (c >= first && c < first + 4) begin
                chk({tag, "_valid"}, 32'(vout), 32'd1);
                chk({tag, "_data"},  32'(dout), 32'(8'h10 + (c - first)));
            end
            if (c == first + 6) chk({tag, "_steady_fill"}, 32'(fill), 32'(exp_fill));
            tick();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        k      = 5'd31;
        rst    = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);

        // Basic release (L=21, rbd=0), RBD delay (rbd=7), SOMF/LMFC coincidence (L=16 ignored, 48 used).
        run_release("basic", 5'd0, 21, 23, 6);
        run_release("rbd7",  5'd7, 21, 30, 13);
        run_release("coinc", 5'd0, 16, 50, 33);

        begin : overflow
            logic saw_valid;
            saw_valid = 1'b0;
            do_reset("ovf");
            for (int c = 0; c < 96; c++) begin
                drive(1'b1, c[7:0], c == 16, 1'b0, 5'd0, c == 90);
                if (vout) saw_valid = 1'b1;
                if (c == 80) begin
                    chk("ovf_full_fill", 32'(fill), 32'd64);
                    chk("ovf_no_err_yet", 32'(err), 32'd0);
                end
                if (c == 81) begin
                    chk("ovf_err", 32'(err), 32'd1);
                    chk("ovf_cleared_fill", 32'(fill), 32'd0);
                end
                if (c == 89) chk("ovf_sticky", 32'(err), 32'd1);
                if (c == 91) begin
                    chk("resync_err_clr", 32'(err), 32'd0);
                    chk("resync_fill", 32'(fill), 32'd0);
                    chk("resync_released", 32'(released), 32'd0);
                end
                if (c == 94) chk("resync_idle_discard", 32'(fill), 32'd0);
                tick();
            end
            chk("ovf_never_valid", 32'(saw_valid), 32'd0);
        end

        do_reset("udf");
        for (int c = 0; c < 60; c++) begin
            drive(c < 35, c[7:0], c == 16, (c % 32) == 21, 5'd7, 1'b0);
            if (c == 35) chk("udf_fill13", 32'(fill), 32'd13);
            if (c == 47) chk("udf_data_47", 32'(dout), 32'h21);
            if (c == 48) begin
                chk("udf_last_valid", 32'(vout), 32'd1);
                chk("udf_last_data", 32'(dout), 32'h22);
                chk("udf_no_err_yet", 32'(err), 32'd0);
            end
            if (c == 49) begin
                chk("udf_err", 32'(err), 32'd1);
                chk("udf_valid_off", 32'(vout), 32'd0);
            end
            if (c == 58) chk("udf_sticky", 32'(err), 32'd1);
            tick();
        end

        begin : resync_mid
            logic saw_valid;
            saw_valid = 1'b0;
            do_reset("rsy");
            for (int c = 0; c < 92; c++) begin
                drive(1'b1, c[7:0], (c == 16) || (c == 64), (c % 32) == 21,
                      (c < 24) ? 5'd4 : 5'd2, c == 23);
                if (c < 89 && vout) saw_valid = 1'b1;
                if (c == 24) chk("rsy_fill_flushed", 32'(fill), 32'd0);
                if (c == 60) chk("rsy_idle_fill", 32'(fill), 32'd0);
                if (c == 87) chk("rsy_rel_early", 32'(released), 32'd0);
                if (c == 88) begin
                    chk("rsy_rel_on", 32'(released), 32'd1);
                    chk("rsy_fill", 32'(fill), 32'd24);
                end
                if (c == 89) begin
                    chk("rsy_valid", 32'(vout), 32'd1);
                    chk("rsy_data40", 32'(dout), 32'h40);
                end
                if (c == 90) chk("rsy_data41", 32'(dout), 32'h41);
                tick();
            end
            chk("rsy_no_old_output", 32'(saw_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
